reg_access_arbiter: RTL and testbench

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

---
 rtl/reg_access_arbiter_if.sv | 34 +++
 rtl/reg_access_arbiter.sv | 170 +++++++++++++++++
 tb/tb_reg_access_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_arbiter_if.sv
// Bus bundle between the three register requesters, the arbiter and the
// register bank. The arbiter uses the slave view; the environment (requesters
// plus bank) uses the master view.
interface reg_access_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Requester side: bit/slice i belongs to requester i (0=CPU, 1=cmd, 2=data)
  logic [2:0]          m_req;
  logic [2:0]          m_rw;
  logic [3*ADDR_W-1:0] m_addr;
  logic [3*DATA_W-1:0] m_wdata;
  logic [2:0]          m_ack;
  logic [2:0]          m_err;
  logic [DATA_W-1:0]   m_rdata;

  // Register bank side
  logic                reg_req;
  logic                reg_rw;
  logic [ADDR_W-1:0]   reg_addr;
  logic [DATA_W-1:0]   reg_wdata;
  logic [DATA_W-1:0]   reg_rdata;
  logic                reg_ack;

  modport slave (
    input  m_req, m_rw, m_addr, m_wdata, reg_rdata, reg_ack,
    output m_ack, m_err, m_rdata, reg_req, reg_rw, reg_addr, reg_wdata
  );

  modport master (
    output m_req, m_rw, m_addr, m_wdata, reg_rdata, reg_ack,
    input  m_ack, m_err, m_rdata, reg_req, reg_rw, reg_addr, reg_wdata
  );
endinterface

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter giving three requesters (CPU, command engine, data
// engine) serialized access to a register bank. Illegal accesses are answered
// locally with an error; a silent bank is abandoned after TIMEOUT cycles.
module reg_access_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int REG_DEPTH = 29,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t              state_reg;
  logic [1:0]          last_grant_reg;
  logic [1:0]          gnt_reg;
  logic                rw_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                reg_req_reg;
  logic [2:0]          m_ack_reg;
  logic [2:0]          m_err_reg;
  logic [DATA_W-1:0]   m_rdata_reg;
  logic [3:0]          wait_cnt_reg;
  logic [3:0]          wait_cnt_next;

  // Requester operands unpacked into arrays; entry 3 is a never-selected pad
  // so a 2-bit index always lands inside the array.
  logic [3:0]          req_vec;
  logic [3:0]          rw_vec;
  logic [ADDR_W-1:0]   addr_arr  [4];
  logic [DATA_W-1:0]   wdata_arr [4];

  assign req_vec = {1'b0, bus.m_req};
  assign rw_vec  = {1'b0, bus.m_rw};

  for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.m_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = bus.m_wdata[gi*DATA_W +: DATA_W];
  end
  assign addr_arr[3]  = '0;
  assign wdata_arr[3] = '0;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Round-robin search starting at the requester after the last one served
  logic       gnt_found;
  logic [1:0] gnt_idx;
  logic [1:0] cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = rr_next(last_grant_reg);
    for (int k = 0; k < 3; k++) begin
      if (!gnt_found && req_vec[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
      cand = rr_next(cand);
    end
  end

  // Legality of the candidate grant: out-of-range address, or a CPU write to
  // a register that is read-only from the CPU's point of view
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_illegal;

  always_comb begin
    sel_rw      = rw_vec[gnt_idx];
    sel_addr    = addr_arr[gnt_idx];
    sel_wdata   = wdata_arr[gnt_idx];
    sel_illegal = (int'(sel_addr) >= REG_DEPTH) ||
                  ((gnt_idx == 2'd0) && !sel_rw &&
                   (int'(sel_addr) inside {4, 5, 6, 7, 9, 16, 17, 18, 19}));
  end

  assign wait_cnt_next = wait_cnt_reg + 4'd1;

  // Transaction FSM: grant in IDLE, hold the bank request in ISSUE, wait for
  // the bank to release its acknowledge in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 2'd2;
      gnt_reg        <= 2'd0;
      rw_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      reg_req_reg    <= 1'b0;
      m_ack_reg      <= '0;
      m_err_reg      <= '0;
      m_rdata_reg    <= '0;
      wait_cnt_reg   <= '0;
    end else begin
      m_ack_reg <= '0;
      m_err_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (gnt_found) begin
            gnt_reg      <= gnt_idx;
            rw_reg       <= sel_rw;
            addr_reg     <= sel_addr;
            wdata_reg    <= sel_wdata;
            wait_cnt_reg <= '0;
            if (sel_illegal) begin
              m_ack_reg      <= onehot3(gnt_idx);
              m_err_reg      <= onehot3(gnt_idx);
              last_grant_reg <= gnt_idx;
              state_reg      <= DONE;
            end else begin
              reg_req_reg <= 1'b1;
              state_reg   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt_reg <= wait_cnt_next;
          if (bus.reg_ack) begin
            reg_req_reg    <= 1'b0;
            if (rw_reg) begin
              m_rdata_reg <= bus.reg_rdata;
            end
            m_ack_reg      <= onehot3(gnt_reg);
            last_grant_reg <= gnt_reg;
            state_reg      <= DONE;
          end else if (wait_cnt_next == TIMEOUT_CNT) begin
            reg_req_reg    <= 1'b0;
            m_ack_reg      <= onehot3(gnt_reg);
            m_err_reg      <= onehot3(gnt_reg);
            last_grant_reg <= gnt_reg;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          if (!bus.reg_ack) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.reg_req   = reg_req_reg;
  assign bus.reg_rw    = rw_reg;
  assign bus.reg_addr  = addr_reg;
  assign bus.reg_wdata = wdata_reg;
  assign bus.m_ack     = m_ack_reg;
  assign bus.m_err     = m_err_reg;
  assign bus.m_rdata   = m_rdata_reg;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: directed requester traffic, a behavioural bank,
// and a transaction-level reference (round-robin order over pending requests,
// legality rules, reference register contents) checked every cycle.
module tb_reg_access_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 29;
  localparam int TMO = 15;
  localparam int BANK_DELAY = 1;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_access_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .REG_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Requester stimulus: per-requester op lists appended by the main sequence
  op_t  ops [3][16];
  int   n_ops [3] = '{0, 0, 0};
  int   ptr [3] = '{0, 0, 0};
  op_t  cur [3];
  logic [2:0] active = 3'b000;
  int   req_cyc [3];
  bit   bank_stall = 1'b0;

  // Observations recorded by the compare process
  int   glog [$];
  int   ack_cnt [3] = '{0, 0, 0};
  int   last_err [3];
  int   last_lat [3];
  logic [DW-1:0] last_rdata;
  int   bus_cycles = 0;
  int   run_len = 0;
  int   last_run = 0;

  function automatic logic [DW-1:0] mem_init(input int a);
    return (a == 2) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(a) * 32'h0101;
  endfunction

  function automatic bit illegal(input int i, input logic rw, input logic [AW-1:0] a);
    return (int'(a) >= DEPTH) ||
           (i == 0 && !rw && (int'(a) inside {4, 5, 6, 7, 9, 16, 17, 18, 19}));
  endfunction

  function automatic int rr_pick(input int last, input logic [2:0] act);
    for (int k = 1; k <= 3; k++) begin
      if (act[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Requester agents: raise a request, hold it until m_ack, then drop it
  initial begin
    bus.m_req = '0; bus.m_rw = '0; bus.m_addr = '0; bus.m_wdata = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          active[i] = 1'b0;
          bus.m_req[i] = 1'b0;
          ptr[i] = n_ops[i];
        end else if (active[i]) begin
          if (bus.m_ack[i]) begin
            active[i] = 1'b0;
            bus.m_req[i] = 1'b0;
          end
        end else if (ptr[i] < n_ops[i]) begin
          cur[i] = ops[i][ptr[i]];
          ptr[i]++;
          active[i] = 1'b1;
          req_cyc[i] = cyc;
          bus.m_req[i] = 1'b1;
          bus.m_rw[i] = cur[i].rw;
          bus.m_addr[i*AW +: AW] = cur[i].addr;
          bus.m_wdata[i*DW +: DW] = cur[i].wdata;
          $display("req %0d: %s addr %0d wdata %08h at cycle %0d", i,
                   cur[i].rw ? "read " : "write", cur[i].addr, cur[i].wdata, cyc);
        end
      end
    end
  end

  // Register bank: acknowledges BANK_DELAY cycles after it first sees reg_req
  logic [DW-1:0] bank_mem [32];
  int bank_wait = 0;
  initial begin
    for (int a = 0; a < 32; a++) bank_mem[a] = mem_init(a);
    bus.reg_ack = 1'b0;
    bus.reg_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.reg_ack = 1'b0;
        bank_wait = 0;
      end else if (bus.reg_ack) begin
        bus.reg_ack = 1'b0;
      end else if (bus.reg_req) begin
        if (!bank_stall && bank_wait >= BANK_DELAY) begin
          bus.reg_ack = 1'b1;
          bank_wait = 0;
          if (bus.reg_rw) begin
            bus.reg_rdata = bank_mem[bus.reg_addr];
          end else begin
            bank_mem[bus.reg_addr] = bus.reg_wdata;
            bus.reg_rdata = 32'hBAD0_0000 ^ 32'(cyc);
          end
        end else begin
          bank_wait++;
        end
      end else begin
        bank_wait = 0;
      end
    end
  end

  // Compare process: transaction-level reference checked every cycle
  logic [DW-1:0] model_mem [32];
  int            model_last = 2;
  logic [DW-1:0] model_rdata = '0;
  initial begin
    int  g;
    bit  ok;
    bit  exp_err;
    for (int a = 0; a < 32; a++) model_mem[a] = mem_init(a);
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        model_last = 2;
        model_rdata = '0;
        run_len = 0;
        chk("rst_reg_req", 64'(bus.reg_req), 0);
        chk("rst_reg_rw", 64'(bus.reg_rw), 0);
        chk("rst_reg_addr", 64'(bus.reg_addr), 0);
        chk("rst_reg_wdata", 64'(bus.reg_wdata), 0);
        chk("rst_m_ack", 64'(bus.m_ack), 0);
        chk("rst_m_err", 64'(bus.m_err), 0);
        chk("rst_m_rdata", 64'(bus.m_rdata), 0);
      end else begin
        chk("ack_at_most_one", 64'($countones(bus.m_ack) <= 1), 1);
        chk("err_without_ack", 64'(bus.m_err & ~bus.m_ack), 0);
        if (bus.reg_req) begin
          bus_cycles++;
          run_len++;
          ok = 1'b0;
          for (int i = 0; i < 3; i++) begin
            if (active[i] && !illegal(i, cur[i].rw, cur[i].addr) &&
                cur[i].rw == bus.reg_rw && cur[i].addr == bus.reg_addr &&
                (cur[i].rw || cur[i].wdata == bus.reg_wdata)) ok = 1'b1;
          end
          chk("bank_op_matches_request", 64'(ok), 1);
        end else begin
          if (run_len > 0) last_run = run_len;
          run_len = 0;
        end
        if (bus.m_ack != 3'b000) begin
          g = bus.m_ack[0] ? 0 : (bus.m_ack[1] ? 1 : 2);
          chk("ack_to_pending_requester", 64'(active[g]), 1);
          chk("grant_order", 64'(g), 64'(rr_pick(model_last, active)));
          exp_err = illegal(g, cur[g].rw, cur[g].addr) || bank_stall;
          chk("m_err", 64'(bus.m_err[g]), 64'(exp_err));
          if (!exp_err) begin
            if (cur[g].rw) model_rdata = model_mem[cur[g].addr];
            else model_mem[cur[g].addr] = cur[g].wdata;
          end
          chk("m_rdata", 64'(bus.m_rdata), 64'(model_rdata));
          glog.push_back(g);
          ack_cnt[g]++;
          last_err[g] = int'(bus.m_err[g]);
          last_lat[g] = cyc - req_cyc[g];
          last_rdata = bus.m_rdata;
          model_last = g;
          $display("ack %0d: err %0d rdata %08h latency %0d at cycle %0d",
                   g, bus.m_err[g], bus.m_rdata, last_lat[g], cyc);
        end
      end
    end
  end

  task automatic push_op(input int i, input logic rw, input int addr, input logic [DW-1:0] wd);
    ops[i][n_ops[i]] = '{rw: rw, addr: AW'(addr), wdata: wd};
    n_ops[i]++;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = (ptr[0] == n_ops[0]) && (ptr[1] == n_ops[1]) &&
             (ptr[2] == n_ops[2]) && (active == 3'b000);
    end
    chk("traffic_completes", 64'(done), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int acks [3];
    int bus0;
    int exp_order [4] = '{0, 1, 2, 0};
    bit seen;

    do_reset();

    // CPU read of addr 2, bank acks one cycle after reg_req
    acks = ack_cnt;
    push_op(0, 1'b1, 2, '0);
    wait_idle();
    chk("t1_acked", 64'(ack_cnt[0] - acks[0]), 1);
    chk("t1_latency", 64'(last_lat[0]), 3);
    chk("t1_rdata", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("t1_err", 64'(last_err[0]), 0);

    // All three requesters together from reset: order 0,1,2,0
    do_reset();
    base = glog.size();
    push_op(0, 1'b1, 1, '0);
    push_op(1, 1'b0, 10, 32'h1111_0010);
    push_op(2, 1'b1, 11, '0);
    push_op(0, 1'b1, 10, '0);
    wait_idle();
    chk("t2_ack_count", 64'(glog.size() - base), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant_seq", 64'((glog.size() > base + k) ? glog[base + k] : -1), 64'(exp_order[k]));
    end
    chk("t2_read_back", 64'(last_rdata), 64'h0000_0000_1111_0010);

    // CPU write to read-only addr 5 is refused without touching the bank
    acks = ack_cnt; bus0 = bus_cycles;
    push_op(0, 1'b0, 5, 32'h5555_5555);
    wait_idle();
    chk("t3_cpu_acked", 64'(ack_cnt[0] - acks[0]), 1);
    chk("t3_cpu_err", 64'(last_err[0]), 1);
    chk("t3_cpu_no_bank", 64'(bus_cycles - bus0), 0);
    acks = ack_cnt; bus0 = bus_cycles;
    push_op(1, 1'b0, 5, 32'hCAFE_0005);
    wait_idle();
    chk("t3_cmd_acked", 64'(ack_cnt[1] - acks[1]), 1);
    chk("t3_cmd_err", 64'(last_err[1]), 0);
    chk("t3_cmd_bank_used", 64'(bus_cycles - bus0 > 0), 1);
    push_op(2, 1'b1, 5, '0);
    wait_idle();
    chk("t3_readback", 64'(last_rdata), 64'h0000_0000_CAFE_0005);

    // Data engine read of addr 30 is out of range
    acks = ack_cnt; bus0 = bus_cycles;
    push_op(2, 1'b1, 30, '0);
    wait_idle();
    chk("t4_acked", 64'(ack_cnt[2] - acks[2]), 1);
    chk("t4_err", 64'(last_err[2]), 1);
    chk("t4_no_bank", 64'(bus_cycles - bus0), 0);

    // Silent bank: timeout after 15 ISSUE cycles, then normal service
    bank_stall = 1'b1;
    acks = ack_cnt;
    push_op(1, 1'b1, 7, '0);
    wait_idle();
    chk("t5_acked", 64'(ack_cnt[1] - acks[1]), 1);
    chk("t5_err", 64'(last_err[1]), 1);
    chk("t5_req_cycles", 64'(last_run), 15);
    chk("t5_rdata_kept", 64'(last_rdata), 64'h0000_0000_CAFE_0005);
    bank_stall = 1'b0;
    push_op(0, 1'b1, 8, '0);
    wait_idle();
    chk("t5_next_err", 64'(last_err[0]), 0);
    chk("t5_next_rdata", 64'(last_rdata), 64'h0000_0000_1000_0808);
    chk("t5_next_latency", 64'(last_lat[0]), 3);

    // Reset mid-ISSUE aborts the access; requester 0 is granted first after
    bank_stall = 1'b1;
    acks = ack_cnt;
    push_op(0, 1'b1, 3, '0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = bus.reg_req;
    end
    chk("t6_issue_started", 64'(seen), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reg_req", 64'(bus.reg_req), 0);
    chk("t6_async_m_ack", 64'(bus.m_ack), 0);
    bank_stall = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("t6_no_ack_for_aborted", 64'(ack_cnt[0] - acks[0]), 0);
    base = glog.size();
    push_op(2, 1'b1, 12, '0);
    push_op(1, 1'b1, 13, '0);
    push_op(0, 1'b1, 14, '0);
    wait_idle();
    chk("t6_first_grant", 64'((glog.size() > base) ? glog[base] : -1), 0);
    chk("t6_ack_count", 64'(glog.size() - base), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
